// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with one access outstanding.
// Round-robin on contested grants; all memory-side and requester-side outputs registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wmask,
  output logic              m_rstrb,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready,
  output logic              m_busy
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e state;
  logic   prio_d;  // data wins the next contested arbitration
  logic   i_elig, d_elig, grant_i, grant_d;

  // A requester still holding req during its own ack cycle is not re-granted.
  always_comb begin
    i_elig  = i_req & ~i_ack;
    d_elig  = d_req & ~d_ack;
    grant_d = d_elig & (~i_elig | prio_d);
    grant_i = i_elig & ~grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      prio_d  <= 1'b0;
      i_rdata <= '0;
      i_ack   <= 1'b0;
      d_rdata <= '0;
      d_ack   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wmask <= '0;
      m_rstrb <= 1'b0;
      m_busy  <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_i) begin
            state   <= StIBusy;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_wmask <= '0;
            m_rstrb <= 1'b1;
            m_busy  <= 1'b1;
          end else if (grant_d) begin
            state   <= StDBusy;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wmask <= d_we ? d_wmask : 4'b0000;
            m_rstrb <= ~d_we;
            m_busy  <= 1'b1;
          end
          // Pointer moves only when both competed for the grant.
          if (i_elig && d_elig) begin
            prio_d <= grant_i;
          end
        end
        StIBusy: begin
          if (m_ready) begin
            state   <= StIdle;
            m_rstrb <= 1'b0;
            m_wmask <= '0;
            m_busy  <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= m_rdata;
          end
        end
        StDBusy: begin
          if (m_ready) begin
            state   <= StIdle;
            m_rstrb <= 1'b0;
            m_wmask <= '0;
            m_busy  <= 1'b0;
            d_ack   <= 1'b1;
            if (m_rstrb) begin
              d_rdata <= m_rdata;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grants, latency, round-robin, stores, reset abort.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask, m_wmask;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rstrb, m_ready, m_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wmask (d_wmask),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wmask (m_wmask),
    .m_rstrb (m_rstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_busy  (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) check("ack_excl", {i_ack, d_ack} == 2'b11, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wmask = '0; m_rdata = '0; m_ready = 0;
    #3;
    check("rst_busy", m_busy, 0);
    check("rst_rstrb", m_rstrb, 0);
    check("rst_addr", m_addr, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single fetch, zero wait states
    i_req = 1; i_addr = 32'h2c; m_rdata = 32'h13;
    check("f0_busy", m_busy, 0);
    tick();
    check("f1_addr", m_addr, 32'h2c);
    check("f1_rstrb", m_rstrb, 1);
    check("f1_busy", m_busy, 1);
    check("f1_ack", i_ack, 0);
    m_ready = 1;
    tick();
    check("f2_ack", i_ack, 1);
    check("f2_rdata", i_rdata, 32'h13);
    check("f2_rstrb", m_rstrb, 0);
    check("f2_busy", m_busy, 0);
    i_req = 0; m_ready = 0;
    tick();
    check("f3_ack", i_ack, 0);
    check("f3_busy", m_busy, 0);

    // m_ready ignored while idle
    m_ready = 1;
    tick();
    check("idle_rdy_ack", {i_ack, d_ack}, 0);
    check("idle_rdy_busy", m_busy, 0);
    m_ready = 0;

    // Store with partial mask; m_rdata must not reach d_rdata
    d_req = 1; d_we = 1; d_addr = 32'h36; d_wdata = 32'hdeadbeef; d_wmask = 4'b0011;
    m_rdata = 32'h55555555;
    tick();
    check("st_wmask", m_wmask, 4'b0011);
    check("st_wdata", m_wdata, 32'hdeadbeef);
    check("st_rstrb", m_rstrb, 0);
    check("st_addr", m_addr, 32'h36);
    m_ready = 1;
    tick();
    check("st_ack", d_ack, 1);
    check("st_rdata", d_rdata, 0);
    check("st_wmask_clr", m_wmask, 0);
    d_req = 0; d_we = 0; d_wmask = 0; m_ready = 0;
    tick();

    // Contested: fetch first, then load in the fetch's ack cycle
    i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
    tick();
    check("rr1_addr", m_addr, 32'h100);
    m_ready = 1; m_rdata = 32'haaaa0001;
    tick();
    check("rr1_iack", i_ack, 1);
    check("rr1_irdata", i_rdata, 32'haaaa0001);
    i_req = 0; m_ready = 0;
    tick();
    check("rr2_addr", m_addr, 32'h200);
    check("rr2_rstrb", m_rstrb, 1);
    m_ready = 1; m_rdata = 32'hbbbb0002;
    tick();
    check("rr2_dack", d_ack, 1);
    check("rr2_drdata", d_rdata, 32'hbbbb0002);
    d_req = 0; m_ready = 0;
    tick();

    // Repeat contest: data now wins
    i_req = 1; d_req = 1; i_addr = 32'h300; d_addr = 32'h400;
    tick();
    check("rr3_addr", m_addr, 32'h400);
    m_ready = 1; m_rdata = 32'hcccc0003;
    tick();
    check("rr3_dack", d_ack, 1);
    check("rr3_drdata", d_rdata, 32'hcccc0003);
    d_req = 0; m_ready = 0;
    tick();
    check("rr4_addr", m_addr, 32'h300);
    m_ready = 1; m_rdata = 32'hdddd0004;
    tick();
    check("rr4_iack", i_ack, 1);
    check("rr4_irdata", i_rdata, 32'hdddd0004);
    check("rr4_drdata_hold", d_rdata, 32'hcccc0003);
    i_req = 0; m_ready = 0;
    tick();

    // Three wait states: busy for 4 cycles, ack in cycle 5, address stable
    i_req = 1; i_addr = 32'h40;
    tick();
    i_addr = 32'h44;
    for (int k = 1; k <= 4; k++) begin
      check("ws_busy", m_busy, 1);
      check("ws_addr", m_addr, 32'h40);
      check("ws_ack", i_ack, 0);
      if (k == 4) begin
        m_ready = 1; m_rdata = 32'h0badf00d;
      end
      tick();
    end
    check("ws_ack5", i_ack, 1);
    check("ws_busy5", m_busy, 0);
    check("ws_rdata", i_rdata, 32'h0badf00d);
    i_req = 0; m_ready = 0;
    tick();

    // Req held through ack: no re-grant in ack cycle, new grant the next
    i_req = 1; i_addr = 32'h50;
    tick();
    m_ready = 1; m_rdata = 32'h11;
    tick();
    check("hold_ack", i_ack, 1);
    m_ready = 0; i_addr = 32'h54;
    tick();
    check("hold_noregrant", m_busy, 0);
    check("hold_ack_off", i_ack, 0);
    tick();
    check("hold_regrant", m_busy, 1);
    check("hold_addr", m_addr, 32'h54);
    m_ready = 1;
    tick();
    check("hold_ack2", i_ack, 1);
    i_req = 0; m_ready = 0;
    tick();

    // Requester drops req mid-access; still completed and acked
    d_req = 1; d_we = 0; d_addr = 32'h60;
    tick();
    d_req = 0;
    tick();
    check("drop_busy", m_busy, 1);
    m_ready = 1; m_rdata = 32'h77;
    tick();
    check("drop_ack", d_ack, 1);
    check("drop_rdata", d_rdata, 32'h77);
    m_ready = 0;
    tick();

    // Store with empty mask
    d_req = 1; d_we = 1; d_wmask = 4'b0000; d_addr = 32'h70; m_rdata = 32'h99;
    tick();
    check("z_wmask", m_wmask, 0);
    check("z_rstrb", m_rstrb, 0);
    check("z_busy", m_busy, 1);
    m_ready = 1;
    tick();
    check("z_ack", d_ack, 1);
    check("z_rdata", d_rdata, 32'h77);
    d_req = 0; d_we = 0; m_ready = 0;
    tick();

    // Asynchronous reset mid-fetch aborts it
    i_req = 1; i_addr = 32'h80;
    tick();
    check("ra_rstrb_pre", m_rstrb, 1);
    #2 reset = 1;
    #1;
    check("ra_rstrb", m_rstrb, 0);
    check("ra_busy", m_busy, 0);
    check("ra_addr", m_addr, 0);
    check("ra_rdata", {i_rdata, d_rdata} == 64'd0, 1);
    i_req = 0; m_ready = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ra_noack", i_ack, 0);
      check("ra_idle", m_busy, 0);
    end
    m_ready = 0;

    // Pointer back to favouring fetch after reset
    i_req = 1; d_req = 1; i_addr = 32'h900; d_addr = 32'ha00;
    tick();
    check("rp_addr", m_addr, 32'h900);
    m_ready = 1;
    tick();
    check("rp_iack", i_ack, 1);
    i_req = 0; m_ready = 0;
    tick();
    check("rp_daddr", m_addr, 32'ha00);
    m_ready = 1;
    tick();
    check("rp_dack", d_ack, 1);
    d_req = 0; m_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
